// File: rtl/msg_validity_checker.sv
// Post-decrypt plaintext checker: walks the decrypted-message RAM through its
// read port and reports whether every byte is a lowercase letter or a space.
module msg_validity_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [7:0]        fail_byte
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int                CNT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  WAIT_END = CNT_W'(RD_LAT - 1);
    // One spare index bit keeps the terminal compare exact when MSG_LEN == 2**ADDR_W.
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(MSG_LEN - 1);

    logic [2:0]       state;
    logic [ADDR_W:0]  index;
    logic [CNT_W-1:0] lat_cnt;
    logic             byte_ok;

    // Plaintext alphabet: space or 'a'..'z'; only ever sampled in CHECK.
    assign byte_ok = (rd_data == 8'h20) || ((rd_data >= 8'h61) && (rd_data <= 8'h7A));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, matching the hardware it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            index     <= '0;
            lat_cnt   <= '0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_byte <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        index     <= '0;
                        rd_addr   <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_byte <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rd_addr <= index[ADDR_W-1:0];
                    lat_cnt <= CNT_W'(1);
                    state   <= (RD_LAT <= 1) ? S_CHECK : S_WAIT;
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == WAIT_END) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!byte_ok) begin
                        fail_addr <= index[ADDR_W-1:0];
                        fail_byte <= rd_data;
                        pass      <= 1'b0;
                        state     <= S_FINISH;
                    end else if (index == LAST_IDX) begin
                        pass  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    rd_addr <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
